// File: rtl/fifo_serial_drain_if.sv
// FIFO read-port and serial-output bundle for fifo_serial_drain.
// master = the drain block; slave = the FIFO / status side.
interface fifo_serial_drain_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              tx;
  logic              busy;
  logic              byte_done;
  logic [7:0]        frame_count;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, byte_done, frame_count
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, byte_done, frame_count
  );
endinterface

// File: rtl/fifo_serial_drain.sv
// Pops bytes from the 8x8 FIFO read port and sends each as a UART frame (start, 8 data LSB first, stop).
// Optional even-parity bit between data and stop: define FIFO_SERIAL_PARITY_EN.
module fifo_serial_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  fifo_serial_drain_if.master  bus
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_W - 1);

`ifdef FIFO_SERIAL_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          count_q, count_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
`ifdef FIFO_SERIAL_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                rd_pop;
  logic                baud_last;
  logic [BAUD_W-1:0]   baud_next;

  // The pop is decoded combinationally so the byte is captured on the same edge it is read.
  assign rd_pop    = (state_q == S_IDLE) & bus.enable & ~bus.fifo_empty;
  assign baud_last = (baud_q == BAUD_LAST);
  assign baud_next = baud_last ? '0 : baud_q + BAUD_W'(1);

  assign bus.fifo_rd     = rd_pop;
  assign bus.tx          = tx_q;
  assign bus.busy        = (state_q != S_IDLE) | rd_pop;
  assign bus.byte_done   = done_q;
  assign bus.frame_count = count_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    count_d  = count_q;
`ifdef FIFO_SERIAL_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rd_pop) begin
          shift_d  = bus.fifo_data;
`ifdef FIFO_SERIAL_PARITY_EN
          parity_d = ^bus.fifo_data;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        baud_d = baud_next;
        if (baud_last) state_d = S_DATA;
      end
      S_DATA: begin
        baud_d = baud_next;
        if (baud_last) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_SERIAL_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_SERIAL_PARITY_EN
      S_PARITY: begin
        baud_d = baud_next;
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        baud_d = baud_next;
        if (baud_last) begin
          state_d = S_IDLE;
          count_d = count_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are registered from the next-state view so tx changes on the same edge as the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_SERIAL_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef FIFO_SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef FIFO_SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: FIFO queue model, per-cycle frame monitor, directed tables and random traffic.
// Define FIFO_SERIAL_PARITY_EN for both files to exercise the parity build.
module tb_fifo_serial_drain;
  localparam int CPB = 4;
`ifdef FIFO_SERIAL_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  typedef struct {
    logic en;
    logic exp_tx;
    logic exp_rd;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  logic rd_clk = 1'b0;
  logic reset  = 1'b1;

  fifo_serial_drain_if bus();

  fifo_serial_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] fq[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_log[$];
  logic [7:0] sent[$];
  bit         par_log[$];
  int         pop_cyc[$];
  bit         mon_active = 0;
  int         phase = 0;
  logic [7:0] cur_byte = '0;
  logic [7:0] rx_byte = '0;
  logic [7:0] exp_count = '0;
  logic       rx_par = 1'b0;
  int         pop_count = 0;
  int         done_count = 0;
  bit         prev_rd = 0;
  bit         rd_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: first-word-fall-through queue popped on edges where fifo_rd was seen high.
  initial begin
    logic [7:0] dummy;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;
    forever begin
      @(posedge rd_clk);
      #1;
      if (rd_seen && fq.size() > 0) dummy = fq.pop_front();
      bus.fifo_empty = (fq.size() == 0);
      bus.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  // Line monitor: expected waveform derived from the popped byte and the frame layout.
  initial begin
    int   idx;
    logic etx;
    logic erd;
    forever begin
      @(negedge rd_clk);
      cyc++;
      if (reset) begin
        mon_active = 0; phase = 0; prev_rd = 0; rd_seen = 0; exp_count = '0;
        exp_bytes.delete(); rx_log.delete(); par_log.delete(); pop_cyc.delete();
        pop_count = 0; done_count = 0;
      end else begin
        if (!mon_active && prev_rd) begin
          mon_active = 1; phase = 0; rx_byte = '0;
          cur_byte = exp_bytes.pop_front();
        end
        erd = bus.enable && !bus.fifo_empty && !mon_active;
        chk("fifo_rd", 32'(bus.fifo_rd), 32'(erd));
        chk("busy", 32'(bus.busy), 32'(mon_active || erd));
        chk("frame_count", 32'(bus.frame_count), 32'(exp_count));
        if (bus.byte_done) done_count++;
        if (mon_active) begin
          idx = phase / CPB;
          if (idx == 0) etx = 1'b0;
          else if (idx <= 8) etx = cur_byte[idx-1];
          else if (idx == NBITS - 1) etx = 1'b1;
          else etx = ^cur_byte;
          chk("tx_frame", 32'(bus.tx), 32'(etx));
          chk("byte_done", 32'(bus.byte_done), 32'(phase == FRAME - 1));
          if (phase % CPB == CPB / 2) begin
            if (idx >= 1 && idx <= 8) rx_byte[idx-1] = bus.tx;
            else if (idx == 9 && NBITS == 11) rx_par = bus.tx;
          end
          if (phase == FRAME - 1) begin
            mon_active = 0;
            exp_count++;
            rx_log.push_back(rx_byte);
            if (NBITS == 11) par_log.push_back(rx_par);
            $display("frame %0d: rx=0x%02h sent=0x%02h at cycle %0d", rx_log.size(), rx_byte, cur_byte, cyc);
          end else begin
            phase++;
          end
        end else begin
          chk("tx_idle", 32'(bus.tx), 32'(1));
          chk("byte_done_idle", 32'(bus.byte_done), 32'(0));
        end
        if (bus.fifo_rd) begin
          pop_count++;
          pop_cyc.push_back(cyc);
          exp_bytes.push_back(bus.fifo_data);
        end
        prev_rd = bus.fifo_rd;
        rd_seen = bus.fifo_rd;
      end
    end
  end

  task automatic do_reset();
    @(posedge rd_clk);
    #2;
    reset = 1'b1;
    bus.enable = 1'b0;
    fq.delete();
    repeat (3) @(posedge rd_clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_log.size() < n && k < budget) begin
      @(negedge rd_clk); #1; k++;
    end
    chk(name, 32'(rx_log.size()), 32'(n));
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int k = 0;
    while (!(mon_active && phase == ph) && k < budget) begin
      @(negedge rd_clk); #1; k++;
    end
    chk(name, 32'(mon_active && phase == ph), 32'(1));
  endtask

  initial begin
    vec_t       tbl[$];
    logic       fbits[$];
    vec_t       v;
    logic [7:0] b;
    int         k;
    int         hi;

    bus.enable = 1'b0;
    repeat (3) @(posedge rd_clk);
    #2;
    reset = 1'b0;

    // Reset state.
    @(negedge rd_clk);
    chk("rst_tx", 32'(bus.tx), 32'(1));
    chk("rst_rd", 32'(bus.fifo_rd), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.byte_done), 32'(0));
    chk("rst_count", 32'(bus.frame_count), 32'(0));

    // T1: single 0xA5 frame, per-cycle table.
    fbits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef FIFO_SERIAL_PARITY_EN
    fbits.push_back(1'b0);
`endif
    fbits.push_back(1'b1);
    v = '{en: 1'b1, exp_tx: 1'b1, exp_rd: 1'b1, exp_busy: 1'b1, exp_done: 1'b0};
    tbl.push_back(v);
    for (int i = 1; i <= FRAME; i++) begin
      v = '{en: 1'b1, exp_tx: fbits[(i-1)/CPB], exp_rd: 1'b0, exp_busy: 1'b1, exp_done: (i == FRAME)};
      tbl.push_back(v);
    end
    v = '{en: 1'b1, exp_tx: 1'b1, exp_rd: 1'b0, exp_busy: 1'b0, exp_done: 1'b0};
    tbl.push_back(v);

    fq.push_back(8'hA5);
    @(posedge rd_clk);
    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.enable = tbl[i].en;
      @(negedge rd_clk);
      chk("t1_tx", 32'(bus.tx), 32'(tbl[i].exp_tx));
      chk("t1_rd", 32'(bus.fifo_rd), 32'(tbl[i].exp_rd));
      chk("t1_busy", 32'(bus.busy), 32'(tbl[i].exp_busy));
      chk("t1_done", 32'(bus.byte_done), 32'(tbl[i].exp_done));
    end
    chk("t1_count", 32'(bus.frame_count), 32'(1));
    chk("t1_pops", 32'(pop_count), 32'(1));
    chk("t1_rx", 32'(rx_log[0]), 32'(8'hA5));

    // T2: empty FIFO with enable high.
    do_reset();
    bus.enable = 1'b1;
    hi = 0;
    repeat (200) begin
      @(negedge rd_clk);
      if (bus.tx === 1'b1 && bus.busy === 1'b0) hi++;
    end
    chk("t2_pops", 32'(pop_count), 32'(0));
    chk("t2_idle_cycles", 32'(hi), 32'(200));

    // T3: eight bytes drained back to back.
    do_reset();
    for (int i = 0; i < 8; i++) fq.push_back(8'(i));
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b1;
    wait_rx(8, 8 * (FRAME + 1) + 50, "t3_wait");
    repeat (2) @(negedge rd_clk);
    chk("t3_pops", 32'(pop_count), 32'(8));
    chk("t3_count", 32'(bus.frame_count), 32'(8));
    for (int i = 0; i < 8; i++) chk("t3_rx", 32'(rx_log[i]), 32'(i));
    for (int i = 1; i < 8; i++) chk("t3_interval", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(FRAME + 1));

    // T4: enable dropped mid-frame.
    do_reset();
    fq.push_back(8'h3C);
    fq.push_back(8'h99);
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b1;
    wait_phase(2 * CPB + 1, FRAME + 20, "t4_wait_data");
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b0;
    wait_rx(1, FRAME + 20, "t4_wait_frame");
    repeat (100) @(negedge rd_clk);
    chk("t4_pops", 32'(pop_count), 32'(1));
    chk("t4_rx", 32'(rx_log[0]), 32'(8'h3C));
    chk("t4_done", 32'(done_count), 32'(1));
    chk("t4_count", 32'(bus.frame_count), 32'(1));

    // T5: reset during bit 3 of 0xFF, with frame_count at 1 beforehand.
    @(posedge rd_clk);
    #2;
    fq.delete();
    fq.push_back(8'hFF);
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b1;
    wait_phase(4 * CPB + 1, FRAME + 20, "t5_wait_bit3");
    @(posedge rd_clk);
    #3;
    reset = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("t5_tx_async", 32'(bus.tx), 32'(1));
    chk("t5_busy_async", 32'(bus.busy), 32'(0));
    chk("t5_count_async", 32'(bus.frame_count), 32'(0));
    repeat (2) @(posedge rd_clk);
    #2;
    reset = 1'b0;
    fq.delete();
    repeat (60) @(negedge rd_clk);
    chk("t5_count", 32'(bus.frame_count), 32'(0));
    chk("t5_done", 32'(done_count), 32'(0));
    chk("t5_rx", 32'(rx_log.size()), 32'(0));

    // T5b: reset while tx is low (bit 3 of 0x00).
    fq.push_back(8'h00);
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b1;
    wait_phase(4 * CPB + 1, FRAME + 20, "t5b_wait_bit3");
    chk("t5b_tx_low", 32'(bus.tx), 32'(0));
    @(posedge rd_clk);
    #3;
    reset = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("t5b_tx_async", 32'(bus.tx), 32'(1));
    repeat (2) @(posedge rd_clk);
    #2;
    reset = 1'b0;

`ifdef FIFO_SERIAL_PARITY_EN
    // T6: parity bits for 0xA5 and 0x07.
    do_reset();
    fq.push_back(8'hA5);
    fq.push_back(8'h07);
    @(posedge rd_clk);
    #2;
    bus.enable = 1'b1;
    wait_rx(2, 2 * (FRAME + 1) + 50, "t6_wait");
    chk("t6_par0", 32'(par_log[0]), 32'(0));
    chk("t6_par1", 32'(par_log[1]), 32'(1));
    chk("t6_interval", 32'(pop_cyc[1] - pop_cyc[0]), 32'(45));
    chk("t6_rx0", 32'(rx_log[0]), 32'(8'hA5));
    chk("t6_rx1", 32'(rx_log[1]), 32'(8'h07));
`endif

    // T7: random pushes and enable toggling, ordering checked end to end.
    do_reset();
    sent.delete();
    for (int c = 0; c < 3000; c++) begin
      @(posedge rd_clk);
      #2;
      if (c % 16 == 0) bus.enable = ($urandom_range(0, 3) != 0);
      if (fq.size() < 8 && $urandom_range(0, 9) == 0) begin
        b = 8'($urandom);
        fq.push_back(b);
        sent.push_back(b);
      end
    end
    bus.enable = 1'b1;
    wait_rx(sent.size(), 10 * (FRAME + 1) + 50, "t7_wait");
    for (int i = 0; i < sent.size(); i++) chk("t7_rx", 32'(rx_log[i]), 32'(sent[i]));
    repeat (2) @(negedge rd_clk);
    chk("t7_count", 32'(bus.frame_count), 32'(8'(sent.size())));

    // T8: frame_count wraps after 256 frames.
    do_reset();
    bus.enable = 1'b1;
    k = 0;
    while (done_count < 256 && k < 256 * (FRAME + 1) + 400) begin
      @(posedge rd_clk);
      #2;
      k++;
      if (fq.size() < 4) fq.push_back(8'(k));
    end
    bus.enable = 1'b0;
    chk("t8_frames", 32'(done_count), 32'(256));
    repeat (3) @(negedge rd_clk);
    chk("t8_wrap", 32'(bus.frame_count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
